// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants, state enum and decode structs for the ALU issue controller.
package alu_issue_ctrl_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_SHIFT = 2'b01,
        CLS_CMP   = 2'b10,
        CLS_BR    = 2'b11
    } op_cls_e;

    localparam logic [2:0] AC_ADD = 3'd0;
    localparam logic [2:0] AC_ADC = 3'd1;
    localparam logic [2:0] AC_SUB = 3'd2;
    localparam logic [2:0] AC_SBC = 3'd3;
    localparam logic [2:0] AC_AND = 3'd4;
    localparam logic [2:0] AC_OR  = 3'd5;
    localparam logic [2:0] AC_XOR = 3'd6;
    localparam logic [2:0] AC_ILL = 3'd7;

    localparam logic [1:0] SC_SHL = 2'd0;
    localparam logic [1:0] SC_SRA = 2'd1;
    localparam logic [1:0] SC_ROL = 2'd2;
    localparam logic [1:0] SC_ROR = 2'd3;

    localparam logic [1:0] BR_Z  = 2'd0;
    localparam logic [1:0] BR_NZ = 2'd1;
    localparam logic [1:0] BR_C  = 2'd2;
    localparam logic [1:0] BR_NC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CF_KEEP = 2'd0,
        CF_ALU  = 2'd1,
        CF_CLR  = 2'd2
    } cflag_e;

    // ALU control fields; drive=0 means the ALU inputs keep their previous values.
    typedef struct packed {
        logic       drive;
        logic [2:0] acode;
        logic [1:0] scode;
        logic       is_shift;
        logic       use_shamt;
        logic [2:0] shamt;
    } alu_ctl_t;

    typedef struct packed {
        logic       sample;
        logic       wen;
        logic       err;
        cflag_e     c_upd;
        logic       z_upd;
        logic       is_br;
        logic [1:0] cond;
    } op_dec_t;

    function automatic logic br_true(input logic [1:0] cond, input logic c, input logic z);
        case (cond)
            BR_Z:    return z;
            BR_NZ:   return !z;
            BR_C:    return c;
            default: return !c;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, response and ALU-control bundle; slave is the controller's view.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_carry_in;
    logic              alu_is_shift;
    logic [1:0]        alu_scode;
    logic [2:0]        alu_acode;
    logic [DATA_W-1:0] alu_r;
    logic              alu_zero;
    logic              alu_carry_out;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_wen;
    logic              rsp_taken;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        input  alu_r, alu_zero, alu_carry_out,
        output req_ready, rsp_valid, rsp_result, rsp_wen, rsp_taken, rsp_err,
        output alu_a, alu_b, alu_carry_in, alu_is_shift, alu_scode, alu_acode
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        output alu_r, alu_zero, alu_carry_out,
        input  req_ready, rsp_valid, rsp_result, rsp_wen, rsp_taken, rsp_err,
        input  alu_a, alu_b, alu_carry_in, alu_is_shift, alu_scode, alu_acode
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of the upper op-word byte into ALU controls,
// response attributes and the flag-update mask.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [7:0] op_hi,
    output alu_ctl_t   ctl,
    output op_dec_t    dec
);
    always_comb begin
        ctl = '0;
        dec = '0;
        case (op_cls_e'(op_hi[7:6]))
            CLS_ALU: begin
                if (op_hi[5:3] == AC_ILL) begin
                    dec.err = 1'b1;
                end else begin
                    ctl.drive  = 1'b1;
                    ctl.acode  = op_hi[5:3];
                    dec.sample = 1'b1;
                    dec.wen    = 1'b1;
                    dec.z_upd  = 1'b1;
                    // Logic ops (acode[2]=1) always leave carry cleared.
                    dec.c_upd  = op_hi[5] ? CF_CLR : CF_ALU;
                end
            end
            CLS_SHIFT: begin
                ctl.drive     = 1'b1;
                ctl.is_shift  = 1'b1;
                ctl.scode     = op_hi[4:3];
                ctl.use_shamt = 1'b1;
                ctl.shamt     = op_hi[2:0];
                dec.sample    = 1'b1;
                dec.wen       = 1'b1;
                dec.z_upd     = 1'b1;
            end
            CLS_CMP: begin
                ctl.drive  = 1'b1;
                ctl.acode  = AC_SUB;
                dec.sample = 1'b1;
                dec.c_upd  = CF_ALU;
                dec.z_upd  = 1'b1;
            end
            default: begin
                dec.is_br = 1'b1;
                dec.cond  = op_hi[4:3];
            end
        endcase
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/control front-end for the 8-bit combinational ALU: one op in flight,
// owns the C/Z flags, evaluates branches and returns a registered response.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_W,
    parameter int OP_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_flags,
    output logic            flag_c,
    output logic            flag_z,
    alu_issue_ctrl_if.slave bus
);
    state_e            state, state_nxt;
    alu_ctl_t          ctl;
    op_dec_t           dec, dec_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic              is_shift_q;
    logic [1:0]        scode_q;
    logic [2:0]        acode_q;
    logic              wen_q, taken_q, err_q;
    logic              req_ready, rsp_valid, accept;

    alu_op_decode u_dec (
        .op_hi (bus.req_op[OP_W-1 -: 8]),
        .ctl   (ctl),
        .dec   (dec)
    );

    wire unused_op_lo = ^bus.req_op[OP_W-9:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = req_ready && bus.req_valid;

    // ALU controls are loaded at accept so they are stable for the whole EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            is_shift_q <= 1'b0;
            scode_q    <= '0;
            acode_q    <= '0;
            result_q   <= '0;
            wen_q      <= 1'b0;
            taken_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                dec_q <= dec;
                if (ctl.drive) begin
                    a_q        <= bus.req_a;
                    b_q        <= ctl.use_shamt ? {{(DATA_W-3){1'b0}}, ctl.shamt} : bus.req_b;
                    is_shift_q <= ctl.is_shift;
                    scode_q    <= ctl.scode;
                    acode_q    <= ctl.acode;
                end
            end
            if (state == ST_EXEC) begin
                result_q <= dec_q.sample ? bus.alu_r : '0;
                wen_q    <= dec_q.wen;
                taken_q  <= dec_q.is_br && br_true(dec_q.cond, flag_c, flag_z);
                err_q    <= dec_q.err;
            end
        end
    end

    // Flags are still pre-update during EXEC, so branch evaluation above sees start-of-EXEC values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (clr_flags) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (state == ST_EXEC) begin
            if (dec_q.c_upd == CF_ALU)      flag_c <= bus.alu_carry_out;
            else if (dec_q.c_upd == CF_CLR) flag_c <= 1'b0;
            if (dec_q.z_upd) flag_z <= bus.alu_zero;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_result   = result_q;
    assign bus.rsp_wen      = wen_q;
    assign bus.rsp_taken    = taken_q;
    assign bus.rsp_err      = err_q;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_is_shift = is_shift_q;
    assign bus.alu_scode    = scode_q;
    assign bus.alu_acode    = acode_q;
    assign bus.alu_carry_in = flag_c;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 8-bit ALU attached.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic clr_flags;
    logic flag_c, flag_z;
    int   n_chk  = 0;
    int   n_fail = 0;

    alu_issue_ctrl_if #(.DATA_W(8), .OP_W(16)) bus ();

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_flags (clr_flags),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: SUB/SBC carry_out means "no borrow".
    logic [8:0] alu_s;
    logic [2:0] sh;
    always_comb begin
        sh    = bus.alu_b[2:0];
        alu_s = '0;
        if (bus.alu_is_shift) begin
            case (bus.alu_scode)
                2'd0:    alu_s = {1'b0, bus.alu_a << sh};
                2'd1:    alu_s = {1'b0, $signed(bus.alu_a) >>> sh};
                2'd2:    alu_s = {1'b0, (bus.alu_a << sh) | (bus.alu_a >> (4'd8 - {1'b0, sh}))};
                default: alu_s = {1'b0, (bus.alu_a >> sh) | (bus.alu_a << (4'd8 - {1'b0, sh}))};
            endcase
        end else begin
            case (bus.alu_acode)
                3'd0:    alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                3'd1:    alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_carry_in};
                3'd2:    alu_s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
                3'd3:    alu_s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {8'd0, bus.alu_carry_in};
                3'd4:    alu_s = {1'b0, bus.alu_a & bus.alu_b};
                3'd5:    alu_s = {1'b0, bus.alu_a | bus.alu_b};
                default: alu_s = {1'b0, bus.alu_a ^ bus.alu_b};
            endcase
        end
        bus.alu_r         = alu_s[7:0];
        bus.alu_carry_out = alu_s[8];
        bus.alu_zero      = (alu_s[7:0] == 8'h00);
    end

    // Stimulus only: issue one op, wait for the response, capture it, then handshake.
    task automatic run_op(input logic [15:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [7:0] ex_b, output logic ex_cin,
                          output logic [7:0] res, output logic wen, output logic taken,
                          output logic err);
        @(posedge clk); #1;
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
        lat = 0; ex_b = '0; ex_cin = 1'b0;
        do begin
            @(posedge clk); lat++;
            #1 bus.req_valid = 1'b0;
            @(negedge clk);
            if (lat == 1) begin ex_b = bus.alu_b; ex_cin = bus.alu_carry_in; end
        end while (!bus.rsp_valid && lat < 10);
        res = bus.rsp_result; wen = bus.rsp_wen; taken = bus.rsp_taken; err = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
    endtask

    int lat; logic [7:0] ex_b, res; logic ex_cin, wen, taken, err;

    task automatic test_reset();
        rst_n = 1'b0; clr_flags = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_chk++; if ({flag_c, flag_z} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {flag_c, flag_z}); end
        n_chk++; if ({bus.alu_a, bus.alu_b, bus.alu_acode, bus.alu_scode, bus.alu_is_shift, bus.alu_carry_in} !== 23'd0) begin
            n_fail++; $display("FAIL reset_alu_ctl got a=%h b=%h ac=%h exp all 0", bus.alu_a, bus.alu_b, bus.alu_acode); end
        n_chk++; if ({bus.rsp_result, bus.rsp_wen, bus.rsp_taken, bus.rsp_err} !== 11'd0) begin
            n_fail++; $display("FAIL reset_rsp_fields got res=%h wen=%b exp 0", bus.rsp_result, bus.rsp_wen); end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_add();
        run_op(16'h0000, 8'h7F, 8'h01, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got=%0d exp=2", lat); end
        n_chk++; if (res !== 8'h80) begin n_fail++; $display("FAIL add_result got=%h exp=80", res); end
        n_chk++; if ({wen, err, taken} !== 3'b100) begin n_fail++; $display("FAIL add_attrs got=%b exp=100", {wen, err, taken}); end
        n_chk++; if ({flag_c, flag_z} !== 2'b00) begin n_fail++; $display("FAIL add_flags got=%b exp=00", {flag_c, flag_z}); end
    endtask

    task automatic test_carry_chain();
        run_op(16'h0000, 8'hFF, 8'h01, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if (res !== 8'h00) begin n_fail++; $display("FAIL add_wrap_result got=%h exp=00", res); end
        n_chk++; if ({flag_c, flag_z} !== 2'b11) begin n_fail++; $display("FAIL add_wrap_flags got=%b exp=11", {flag_c, flag_z}); end
        n_chk++; if (bus.alu_carry_in !== 1'b1) begin n_fail++; $display("FAIL idle_carry_in got=%b exp=1", bus.alu_carry_in); end
        run_op(16'h0800, 8'h00, 8'h00, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if (ex_cin !== 1'b1) begin n_fail++; $display("FAIL adc_carry_in got=%b exp=1", ex_cin); end
        n_chk++; if (res !== 8'h01) begin n_fail++; $display("FAIL adc_result got=%h exp=01", res); end
        n_chk++; if ({flag_c, flag_z} !== 2'b00) begin n_fail++; $display("FAIL adc_flags got=%b exp=00", {flag_c, flag_z}); end
    endtask

    task automatic test_cmp_branch();
        run_op(16'h8000, 8'h05, 8'h05, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if (wen !== 1'b0) begin n_fail++; $display("FAIL cmp_wen got=%b exp=0", wen); end
        n_chk++; if ({flag_c, flag_z} !== 2'b11) begin n_fail++; $display("FAIL cmp_flags got=%b exp=11", {flag_c, flag_z}); end
        run_op(16'hC000, 8'hAA, 8'hBB, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if ({taken, wen, err} !== 3'b100) begin n_fail++; $display("FAIL br_z_attrs got=%b exp=100", {taken, wen, err}); end
        n_chk++; if ({bus.alu_a, ex_b} !== 16'h0505) begin n_fail++; $display("FAIL br_alu_hold got=%h exp=0505", {bus.alu_a, ex_b}); end
        run_op(16'hC800, 8'h00, 8'h00, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if (taken !== 1'b0) begin n_fail++; $display("FAIL br_nz_taken got=%b exp=0", taken); end
        n_chk++; if ({flag_c, flag_z} !== 2'b11) begin n_fail++; $display("FAIL br_flags got=%b exp=11", {flag_c, flag_z}); end
    endtask

    task automatic test_shift();
        run_op(16'h5300, 8'h81, 8'hFF, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if (ex_b !== 8'h03) begin n_fail++; $display("FAIL rol_alu_b got=%h exp=03", ex_b); end
        n_chk++; if (res !== 8'h0C) begin n_fail++; $display("FAIL rol_result got=%h exp=0c", res); end
        n_chk++; if (wen !== 1'b1) begin n_fail++; $display("FAIL rol_wen got=%b exp=1", wen); end
        n_chk++; if ({flag_c, flag_z} !== 2'b10) begin n_fail++; $display("FAIL rol_flags got=%b exp=10", {flag_c, flag_z}); end
    endtask

    task automatic test_illegal();
        run_op(16'h3800, 8'h12, 8'h34, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if ({err, wen} !== 2'b10) begin n_fail++; $display("FAIL ill_attrs got=%b exp=10", {err, wen}); end
        n_chk++; if (res !== 8'h00) begin n_fail++; $display("FAIL ill_result got=%h exp=00", res); end
        n_chk++; if ({flag_c, flag_z} !== 2'b10) begin n_fail++; $display("FAIL ill_flags got=%b exp=10", {flag_c, flag_z}); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        bus.req_op = 16'h0000; bus.req_a = 8'h01; bus.req_b = 8'h01; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_op = 16'h0800; bus.req_a = 8'h55;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if ({bus.rsp_valid, bus.req_ready} !== 2'b10) begin
                n_fail++; $display("FAIL stall_hs[%0d] got valid/ready=%b exp=10", i, {bus.rsp_valid, bus.req_ready}); end
            n_chk++; if (bus.rsp_result !== 8'h02) begin
                n_fail++; $display("FAIL stall_result[%0d] got=%h exp=02", i, bus.rsp_result); end
        end
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        n_chk++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL stall_release got valid/ready=%b exp=01", {bus.rsp_valid, bus.req_ready}); end
    endtask

    task automatic test_clr_flags();
        @(posedge clk); #1;
        bus.req_op = 16'h0000; bus.req_a = 8'hFF; bus.req_b = 8'h01; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        @(negedge clk);
        n_chk++; if ({bus.rsp_valid, bus.rsp_result} !== 9'h100) begin
            n_fail++; $display("FAIL clr_exec_rsp got=%h exp=100", {bus.rsp_valid, bus.rsp_result}); end
        n_chk++; if ({flag_c, flag_z} !== 2'b00) begin n_fail++; $display("FAIL clr_exec_flags got=%b exp=00", {flag_c, flag_z}); end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        run_op(16'h0000, 8'hFF, 8'h01, lat, ex_b, ex_cin, res, wen, taken, err);
        @(posedge clk); #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        @(negedge clk);
        n_chk++; if ({flag_c, flag_z} !== 2'b00) begin n_fail++; $display("FAIL clr_idle_flags got=%b exp=00", {flag_c, flag_z}); end
    endtask

    task automatic test_reset_mid();
        run_op(16'h0000, 8'hFF, 8'h01, lat, ex_b, ex_cin, res, wen, taken, err);
        @(posedge clk); #1;
        bus.req_op = 16'h0000; bus.req_a = 8'h7F; bus.req_b = 8'h01; bus.req_valid = 1'b1;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rst_mid_hs got valid/ready=%b exp=01", {bus.rsp_valid, bus.req_ready}); end
        n_chk++; if ({flag_c, flag_z, bus.alu_a} !== 10'd0) begin
            n_fail++; $display("FAIL rst_mid_state got flags=%b alu_a=%h exp 0", {flag_c, flag_z}, bus.alu_a); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard got=%b exp=0", bus.rsp_valid); end
        run_op(16'h0000, 8'h7F, 8'h01, lat, ex_b, ex_cin, res, wen, taken, err);
        n_chk++; if ({lat == 2, res} !== 9'h180) begin
            n_fail++; $display("FAIL rst_recover got lat=%0d res=%h exp lat=2 res=80", lat, res); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_cmp_branch();
        test_shift();
        test_illegal();
        test_back_to_back();
        test_clr_flags();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential issue/control front-end that drives the 8-bit combinational ALU's control interface and consumes its result and flags: acode, scode, is_shift and carry_in out; R, zero and carry_out back.
- Accepts one operation at a time over a valid/ready request channel and owns the architectural carry (C) and zero (Z) flag registers.
- Feeds C back as ALU carry-in and evaluates flag-conditional branches.
- Returns result, write-enable, branch-taken and error over a valid/ready response channel.

Parameters:
DATA_W, 8, operand/result width (ALU is 8-bit; other values unsupported)
OP_W, 16, request operation word width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_op  in  16  operation word (format below)
req_a  in  8  operand A
req_b  in  8  operand B (ignored for shift/branch)
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_carry_in  out  1  to ALU carry_in (= flag_c)
alu_is_shift  out  1  to ALU is_shift
alu_scode  out  2  to ALU scode
alu_acode  out  3  to ALU acode
alu_r  in  8  ALU result
alu_zero  in  1  ALU zero
alu_carry_out  in  1  ALU carry_out
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_result  out  8  result to write back
rsp_wen  out  1  result must be written back
rsp_taken  out  1  branch taken
rsp_err  out  1  illegal operation
clr_flags  in  1  synchronous clear of C and Z
flag_c  out  1  carry flag
flag_z  out  1  zero flag

Behaviour:
- Op word classes, by op[15:14]:
  - 00 ALU: op[13:11] = acode; 111 is illegal.
  - 01 SHIFT: op[12:11] = scode, op[10:8] = shamt.
  - 10 CMP: subtract A-B.
  - 11 BR: op[12:11] = cond (00 Z=1, 01 Z=0, 10 C=1, 11 C=0).
  - All other bits are ignored.
- FSM IDLE -> EXEC -> RESP -> IDLE. Reset state is IDLE.
- Reset values: all outputs 0, flags 0, internal operand/op registers 0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op/A/B, go to EXEC.
- EXEC:
  - req_ready=0. ALU control is driven from latched registers.
  - ALU class: acode passes through, is_shift=0, alu_b = B.
  - SHIFT class: is_shift=1, alu_b = {5'b0, shamt}.
  - CMP class: acode=010, is_shift=0, alu_b = B.
  - BR class, or illegal: ALU inputs hold their last values; no ALU sampling.
  - Sample alu_r/alu_zero/alu_carry_out at the end of EXEC into rsp registers, update flags, go to RESP.
  - Exactly one EXEC cycle: latency from accept to rsp_valid = 2 cycles.
- Flag update at end of EXEC:
  - ALU acode 000-011: C<=alu_carry_out, Z<=alu_zero.
  - ALU acode 100-110: C<=0, Z<=alu_zero.
  - SHIFT: Z<=alu_zero, C unchanged.
  - CMP: C<=alu_carry_out, Z<=alu_zero.
  - BR and illegal: no change.
- alu_carry_in always equals the flag_c register value, including in IDLE/RESP.
- Response fields:
  - rsp_wen = 1 for legal ALU and SHIFT; 0 for CMP, BR, illegal.
  - rsp_taken = 1 only for BR with cond true, evaluated on the flags at start of EXEC.
  - rsp_err = 1 only for ALU acode 111; rsp_result=0 in that case.
- RESP:
  - rsp_valid=1; response fields stable until the handshake.
  - On rsp_ready go to IDLE; the earliest next accept is the following cycle (no bubble-free back-to-back).
- clr_flags: clears C,Z at the next edge in any state. If it coincides with a flag update in EXEC, the clear wins.
- rst_n asserted mid-operation: immediate return to IDLE, rsp_valid drops asynchronously, the in-flight op is discarded, flags are 0.
- req_valid while not in IDLE is ignored (req_ready=0); the requester holds.

Decomposition:
- Shared package holds:
  - class constants CLS_ALU/SHIFT/CMP/BR.
  - acode constants ADD, ADC, SUB, SBC, AND, OR, XOR.
  - scode constants SHL, SRA, ROL, ROR.
  - branch cond constants.
  - FSM state enum.
- One sub-module, alu_op_decode: combinational op-word -> ALU controls, wen, err, flag-update mask. The FSM, flags and response registers stay in the top.

Test Plan:
- Reset, then ALU ADD A=8'h7F B=8'h01 -> rsp_valid 2 cycles after accept, result 8'h80, wen=1, C=0, Z=0.
- ADD 8'hFF+8'h01, then ADC 8'h00+8'h00 -> first: result 8'h00, C=1, Z=1; second: alu_carry_in=1, result 8'h01, C=0, Z=0.
- CMP A=8'h05 B=8'h05 then BR cond=00 -> CMP wen=0 and Z=1; BR taken=1. A following BR cond=01 gives taken=0.
- SHIFT scode=10 shamt=3 A=8'h81 -> alu_b=8'h03, result 8'h0C, C unchanged, wen=1.
- ALU acode=111 -> err=1, wen=0, result 8'h00, flags unchanged.
- Hold rsp_ready=0 for 5 cycles with new req_valid asserted -> response stable, req_ready=0. Pulse clr_flags in the same cycle as an EXEC flag update -> C=Z=0. Assert rst_n low mid-EXEC -> rsp_valid=0 and IDLE.
